// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, source-select encoding and the writeback payload type
// used by the writeback arbiter and its scoreboard.
package writeback_arbiter_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/writeback_arbiter_scoreboard.sv
// Register pending-write tracker: busy vector set at issue, cleared at writeback.
// Build with WB_BYPASS_EN to let a same-cycle writeback satisfy a source lookup.
module wb_scoreboard
   import writeback_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  xwe,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  rd_busy,
   output logic                  fwd_rs1_valid,
   output logic                  fwd_rs2_valid
);

   logic [NUM_REGS-1:0] busy;
   logic                byp1, byp2;

   // Set is written after clear so a same-register collision leaves it pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (xwe)
            busy[rd_addr] <= 1'b0;
         if (issue_valid && issue_rd != '0)
            busy[issue_rd] <= 1'b1;
      end
   end

`ifdef WB_BYPASS_EN
   assign byp1 = xwe && rd_addr == rs1_addr && rs1_addr != '0;
   assign byp2 = xwe && rd_addr == rs2_addr && rs2_addr != '0;
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   assign fwd_rs1_valid = byp1;
   assign fwd_rs2_valid = byp2;
   assign rs1_busy      = rs1_addr != '0 && busy[rs1_addr] && !byp1;
   assign rs2_busy      = rs2_addr != '0 && busy[rs2_addr] && !byp2;
   assign rd_busy       = issue_rd != '0 && busy[issue_rd];

endmodule

// File: rtl/writeback_arbiter.sv
// Two-source (ALU/load) writeback arbiter with anti-starvation for loads and a
// registered register-file write port. Optional macro: WB_BYPASS_EN.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]       mem_data,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  rd_busy,
   output logic                  xwe,
   output logic [REG_ADDR_W-1:0] rd_addr,
   output logic [XLEN-1:0]       wdata,
   output logic                  fwd_rs1_valid,
   output logic                  fwd_rs2_valid
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;
   logic       starved;
   logic       grant;
   src_e       sel;
   wb_req_t    win;
   wb_req_t    wb_q;
   logic       xwe_q;
   logic       accept;

   assign starved = starve_cnt == LIMIT;

   always_comb begin
      grant = 1'b0;
      sel   = SRC_ALU;
      if (!rst) begin
         if (mem_valid && (starved || !alu_valid)) begin
            grant = 1'b1;
            sel   = SRC_MEM;
         end else if (alu_valid) begin
            grant = 1'b1;
            sel   = SRC_ALU;
         end
      end
   end

   assign alu_ready = grant && sel == SRC_ALU;
   assign mem_ready = grant && sel == SRC_MEM;
   assign win       = (sel == SRC_MEM) ? wb_req_t'{mem_rd, mem_data}
                                       : wb_req_t'{alu_rd, alu_data};
   assign accept    = grant && win.rd != '0;

   always_ff @(posedge clk) begin
      if (rst)
         starve_cnt <= '0;
      else if (mem_ready)
         starve_cnt <= '0;
      else if (mem_valid && !starved)
         starve_cnt <= starve_cnt + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         xwe_q <= 1'b0;
         wb_q  <= '0;
      end else begin
         xwe_q <= accept;
         if (accept)
            wb_q <= win;
      end
   end

   // A write already registered when reset arrives is suppressed, not emitted.
   assign xwe     = xwe_q && !rst;
   assign rd_addr = rst ? '0 : wb_q.rd;
   assign wdata   = rst ? '0 : wb_q.data;

   wb_scoreboard u_sb (
      .clk           (clk),
      .rst           (rst),
      .issue_valid   (issue_valid),
      .issue_rd      (issue_rd),
      .xwe           (xwe),
      .rd_addr       (rd_addr),
      .rs1_addr      (rs1_addr),
      .rs2_addr      (rs2_addr),
      .rs1_busy      (rs1_busy),
      .rs2_busy      (rs2_busy),
      .rd_busy       (rd_busy),
      .fwd_rs1_valid (fwd_rs1_valid),
      .fwd_rs2_valid (fwd_rs2_valid)
   );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed scenarios then random traffic,
// checked against a pending-set / starvation-count reference model.
module tb_writeback_arbiter;
   import writeback_arbiter_pkg::*;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int LIMIT = 4;

   logic        clk = 1'b0, rst = 1'b1;
   logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
   logic        alu_ready, mem_ready;
   logic [4:0]  alu_rd = '0, mem_rd = '0, issue_rd = '0, rs1_addr = '0, rs2_addr = '0;
   logic [31:0] alu_data = '0, mem_data = '0;
   logic        rs1_busy, rs2_busy, rd_busy, xwe, fwd_rs1_valid, fwd_rs2_valid;
   logic [4:0]  rd_addr;
   logic [31:0] wdata;

   always #5 clk = ~clk;

   writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
      .xwe(xwe), .rd_addr(rd_addr), .wdata(wdata),
      .fwd_rs1_valid(fwd_rs1_valid), .fwd_rs2_valid(fwd_rs2_valid)
   );

   typedef struct {
      bit rst, av, mv, iv;
      bit [4:0] ard, mrd, ird, rs1, rs2;
      bit [31:0] adat, mdat;
   } stim_t;

   typedef struct {
      bit we;
      bit [4:0] rd;
      bit [31:0] data;
   } exp_t;

   exp_t expq[$];
   int   checks = 0, errors = 0;

   // Reference model state: pending register set, stall count, write in flight.
   bit       pend[32];
   int       starve = 0;
   bit       wr_v = 0;
   bit [4:0] wr_rd = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: each cycle's registered write port against what the model queued.
   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("xwe", xwe, 32'(e.we));
         if (e.we) begin
            chk("rd_addr", rd_addr, 32'(e.rd));
            chk("wdata", wdata, e.data);
         end
      end
   end

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   task automatic step(input stim_t s);
      bit gm, ga, ewr, b1, b2;
      bit [4:0] trd;
      bit [31:0] tdat;
      exp_t e;
      @(negedge clk);
      #2;
      rst = s.rst; alu_valid = s.av; alu_rd = s.ard; alu_data = s.adat;
      mem_valid = s.mv; mem_rd = s.mrd; mem_data = s.mdat;
      issue_valid = s.iv; issue_rd = s.ird; rs1_addr = s.rs1; rs2_addr = s.rs2;
      #1;
      gm  = !s.rst && s.mv && (!s.av || starve == LIMIT);
      ga  = !s.rst && s.av && !gm;
      ewr = wr_v && !s.rst;
      b1  = BYP && ewr && wr_rd == s.rs1 && s.rs1 != 0;
      b2  = BYP && ewr && wr_rd == s.rs2 && s.rs2 != 0;
      chk("alu_ready", alu_ready, 32'(ga));
      chk("mem_ready", mem_ready, 32'(gm));
      chk("xwe_now", xwe, 32'(ewr));
      chk("rs1_busy", rs1_busy, 32'(s.rs1 != 0 && pend[s.rs1] && !b1));
      chk("rs2_busy", rs2_busy, 32'(s.rs2 != 0 && pend[s.rs2] && !b2));
      chk("rd_busy", rd_busy, 32'(s.ird != 0 && pend[s.ird]));
      chk("fwd_rs1", fwd_rs1_valid, 32'(b1));
      chk("fwd_rs2", fwd_rs2_valid, 32'(b2));
      if (s.rst) begin
         chk("rst_rd_addr", rd_addr, 32'd0);
         chk("rst_wdata", wdata, 32'd0);
      end
      e = '{default: 0};
      if (s.rst) begin
         foreach (pend[i]) pend[i] = 0;
         starve = 0;
         wr_v = 0;
      end else begin
         if (ewr) pend[wr_rd] = 0;
         if (s.iv && s.ird != 0) pend[s.ird] = 1;
         if (gm) starve = 0;
         else if (s.mv && starve < LIMIT) starve++;
         trd  = gm ? s.mrd : s.ard;
         tdat = gm ? s.mdat : s.adat;
         wr_v = (ga || gm) && trd != 0;
         wr_rd = trd;
         if (wr_v) e = '{1'b1, trd, tdat};
      end
      expq.push_back(e);
   endtask

   initial begin
      stim_t s;
      foreach (pend[i]) pend[i] = 0;
      s = idle(); s.rst = 1;
      step(s); step(s);

      // Single ALU result lands one cycle later.
      s = idle(); s.av = 1; s.ard = 5; s.adat = 32'h1234; step(s);
      s = idle(); step(s);

      // Both sources busy: mem is forced through after LIMIT stalls, then again.
      for (int i = 0; i < 11; i++) begin
         s = idle(); s.av = 1; s.ard = 5'(i + 1); s.adat = 32'hA000 + i;
         s.mv = 1; s.mrd = 5'(20 + (i % 8)); s.mdat = 32'hB000 + i;
         step(s);
      end
      s = idle(); step(s);

      // Pending reg 7 cleared by a load writeback.
      s = idle(); s.iv = 1; s.ird = 7; step(s);
      s = idle(); s.rs1 = 7; s.ird = 7; step(s);
      s = idle(); s.rs1 = 7; s.mv = 1; s.mrd = 7; s.mdat = 32'hCAFE; step(s);
      s = idle(); s.rs1 = 7; s.rs2 = 7; step(s);
      s = idle(); s.rs1 = 7; step(s);

      // Re-issue of reg 9 on its own writeback cycle keeps it pending.
      s = idle(); s.iv = 1; s.ird = 9; step(s);
      s = idle(); s.av = 1; s.ard = 9; s.adat = 32'h99; step(s);
      s = idle(); s.iv = 1; s.ird = 9; s.rs1 = 9; step(s);
      s = idle(); s.rs1 = 9; s.ird = 9; step(s);

      // Write to x0 is accepted and dropped; x0 never pending.
      s = idle(); s.av = 1; s.ard = 0; s.adat = 32'hFFFF_FFFF; step(s);
      s = idle(); s.iv = 1; s.ird = 0; step(s);
      s = idle(); s.rs1 = 0; step(s);

      // Reset right after a transfer suppresses the write and clears busy.
      s = idle(); s.iv = 1; s.ird = 3; step(s);
      s = idle(); s.av = 1; s.ard = 12; s.adat = 32'h5555; step(s);
      s = idle(); s.rst = 1; s.av = 1; s.ard = 4; s.mv = 1; s.mrd = 6; s.rs1 = 3; step(s);
      s = idle(); s.rs1 = 3; s.rs2 = 12; step(s);

      for (int n = 0; n < 600; n++) begin
         s.rst  = ($urandom_range(0, 59) == 0);
         s.av   = ($urandom_range(0, 2) != 0);
         s.ard  = 5'($urandom_range(0, 7));
         s.adat = $urandom;
         s.mv   = ($urandom_range(0, 2) != 0);
         s.mrd  = 5'($urandom_range(0, 7));
         s.mdat = $urandom;
         s.iv   = ($urandom_range(0, 1) != 0);
         s.ird  = 5'($urandom_range(0, 7));
         s.rs1  = 5'($urandom_range(0, 7));
         s.rs2  = 5'($urandom_range(0, 31));
         step(s);
      end

      s = idle(); step(s);
      @(negedge clk);
      #1;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d entries want 0", expq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the count of consecutive mem-stall cycles that forces a mem grant; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the only clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports alu_valid/alu_ready/alu_rd/alu_data, in/out/in/in, 1/1/5/32, ALU result handshake.
REQ-005 SHALL have ports mem_valid/mem_ready/mem_rd/mem_data, in/out/in/in, 1/1/5/32, load-unit result handshake.
REQ-006 SHALL have ports issue_valid/issue_rd, in/in, 1/5, marks destination register pending at issue.
REQ-007 SHALL have ports rs1_addr/rs2_addr, in/in, 5/5, decode source operands to check.
REQ-008 SHALL have ports rs1_busy/rs2_busy/rd_busy, out/out/out, 1 each, pending status of rs1_addr/rs2_addr/issue_rd.
REQ-009 SHALL have ports xwe/rd_addr/wdata, out/out/out, 1/5/32, register-file write port.
REQ-010 SHALL have ports fwd_rs1_valid/fwd_rs2_valid, out/out, 1/1, wdata is bypassable to that operand this cycle.

Function
REQ-011 SHALL grant at most one source per cycle; ready asserted combinationally to the winner only; transfer = valid & ready.
REQ-012 SHALL grant alu over mem by default; when the starve counter equals STARVE_LIMIT, mem wins the next cycle it is valid.
REQ-013 SHALL increment starve counter each cycle mem_valid=1 and mem_ready=0, saturating at STARVE_LIMIT; clear it on any mem transfer.
REQ-014 SHALL register the accepted result: xwe=1, rd_addr, wdata valid exactly one cycle after the transfer; xwe=0 in cycles with no transfer.
REQ-015 SHALL accept a transfer with rd=0, discard it, and keep xwe=0 the following cycle.
REQ-016 SHALL hold a 32-bit busy vector; issue_valid with issue_rd!=0 sets busy[issue_rd] at the clock edge.
REQ-017 SHALL clear busy[rd_addr] at the edge ending a cycle with xwe=1.
REQ-018 SHALL let set win when issue set and writeback clear target the same register in the same cycle.
REQ-019 SHALL drive rs1_busy/rs2_busy/rd_busy combinationally from busy; register 0 always reads not busy.
REQ-020 SHALL never accept a source valid while rst=1 (both ready=0).

Reset
REQ-021 SHALL on rst: xwe=0, rd_addr=0, wdata=0, busy vector=0, starve counter=0, fwd_rs1_valid=fwd_rs2_valid=0.
REQ-022 SHALL discard any in-flight registered write on mid-operation reset; no write leaves the block in the cycle after reset.

Configuration
REQ-023 SHALL support macro WB_BYPASS_EN.
REQ-024 SHALL with WB_BYPASS_EN: when xwe=1 and rd_addr==rsN_addr!=0, force rsN_busy=0 and fwd_rsN_valid=1 in that cycle.
REQ-025 SHALL without WB_BYPASS_EN: fwd_rs1_valid=fwd_rs2_valid=0 constantly; rsN_busy reflects the busy vector only.

Structure
REQ-026 SHALL take XLEN=32, REG_ADDR_W=5 and the source-select encoding (SRC_ALU, SRC_MEM) from the shared package.
REQ-027 SHALL place the busy vector, set/clear and lookup logic in sub-module wb_scoreboard; arbitration and output register stay in the top.

Verification
REQ-028 SHALL cover: alu_valid=1 rd=5 data=0x1234 -> alu_ready=1 same cycle; next cycle xwe=1 rd_addr=5 wdata=0x1234.
REQ-029 SHALL cover: alu and mem valid continuously, STARVE_LIMIT=4 -> alu granted 4 cycles, mem granted cycle 5, counter back to 0.
REQ-030 SHALL cover: issue_rd=7; mem writes rd=7 -> busy set, rs1_addr=7 shows busy until xwe cycle; with WB_BYPASS_EN busy=0 and fwd_rs1_valid=1 in the xwe cycle.
REQ-031 SHALL cover: issue_rd=9 in the same cycle xwe=1 rd_addr=9 -> busy[9] remains 1.
REQ-032 SHALL cover: alu_valid rd=0 data=0xFFFF_FFFF -> accepted, xwe stays 0; issue_rd=0 -> rd_busy=0.
REQ-033 SHALL cover: rst asserted the cycle after a transfer -> xwe=0 next cycle, all busy clear, both ready=0 during rst.
